// File: rtl/inv_addkey_mixcol.sv
// ============================================================================
// Module      : inv_addkey_mixcol
// Description : AES-128 inverse-round stage that applies AddRoundKey and then
//               InvMixColumns (skipped on the final round).
//               INV_MIX_PARALLEL_EN: transform all four columns in one cycle
//               instead of one column per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module inv_addkey_mixcol (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic [127:0] round_key,
   input  logic         last_round,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MIX  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t       r_state;
   logic [127:0] r_work;
   logic         r_skip;
   logic         r_out_valid;
   logic         r_busy;
   logic [127:0] w_mixed;
   logic         w_last_col;

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = col[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

`ifdef INV_MIX_PARALLEL_EN
   for (genvar c = 0; c < 4; c++) begin : g_col
      assign w_mixed[127-32*c -: 32] = inv_mix_col(r_work[127-32*c -: 32]);
   end
   assign w_last_col = 1'b1;
`else
   logic [1:0]  r_col;
   logic [31:0] w_col_in;
   logic [31:0] w_col_out;

   // One shared column unit; the selected column is spliced back into the word.
   always_comb begin
      w_col_in = r_work[127:96];
      case (r_col)
         2'd0: w_col_in = r_work[127:96];
         2'd1: w_col_in = r_work[95:64];
         2'd2: w_col_in = r_work[63:32];
         2'd3: w_col_in = r_work[31:0];
      endcase
   end

   assign w_col_out = inv_mix_col(w_col_in);

   always_comb begin
      w_mixed = r_work;
      case (r_col)
         2'd0: w_mixed = {w_col_out, r_work[95:0]};
         2'd1: w_mixed = {r_work[127:96], w_col_out, r_work[63:0]};
         2'd2: w_mixed = {r_work[127:64], w_col_out, r_work[31:0]};
         2'd3: w_mixed = {r_work[127:32], w_col_out};
      endcase
   end

   assign w_last_col = (r_col == 2'd3);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_work      <= '0;
         r_skip      <= 1'b0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
`ifndef INV_MIX_PARALLEL_EN
         r_col       <= 2'd0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid) begin
                  r_work <= state_in ^ round_key;
                  r_skip <= last_round;
                  r_busy <= 1'b1;
`ifndef INV_MIX_PARALLEL_EN
                  r_col  <= 2'd0;
`endif
                  if (last_round) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                  end else begin
                     r_state     <= ST_MIX;
                  end
               end
            end
            ST_MIX: begin
               if (r_skip) begin
                  r_state     <= ST_DONE;
                  r_out_valid <= 1'b1;
               end else begin
                  r_work <= w_mixed;
`ifndef INV_MIX_PARALLEL_EN
                  r_col  <= r_col + 2'd1;
`endif
                  if (w_last_col) begin
                     r_state     <= ST_DONE;
                     r_out_valid <= 1'b1;
                  end
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  r_state     <= ST_IDLE;
                  r_out_valid <= 1'b0;
                  r_busy      <= 1'b0;
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_out_valid <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   // Gated by rst_n so the block never advertises readiness while held in reset.
   assign in_ready  = (r_state == ST_IDLE) && rst_n;
   assign out_valid = r_out_valid;
   assign busy      = r_busy;
   assign state_out = r_work;

endmodule

`default_nettype wire
